hd_operand_stager: RTL and testbench

Sequential wrapper stage that sits directly upstream and downstream of the 32-in/32-out combinational Hacker's-Delight core (`x0..x31` / `y0..y31`). It assembles a 32-bit operand from a byte-wide valid/ready stream and drives it onto the core's `x` bus, holding it stable. After a programmable settle time it captures the core's `y` bus into an output register and presents it on a valid/ready result interface. The core needs no clock; this block provides all sequencing around it.

---
 rtl/hd_operand_stager.sv | 231 +++++++++++++++++++++++
 tb/tb_hd_operand_stager.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd_operand_stager.sv
// ---------------------------------------------------------------------------
// hd_operand_stager
//
// Sequential wrapper around the 32-in/32-out combinational Hacker's-Delight
// core. It collects a 32-bit operand from a byte stream (LSB first) and drives
// it, registered and stable, onto the core's x bus. SETTLE cycles after the
// last byte it captures the core's y bus and offers it on a result stream.
//
// Parameters
//   SETTLE     cycles from operand completion to result capture (1..15)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort; wins over every other event on that edge
//   s_valid    input byte valid
//   s_ready    block accepts a byte (high only in LOAD)
//   s_data     operand byte, least-significant byte first
//   core_x     registered operand to the core (bit i drives xi)
//   core_y     core result (bit i from yi)
//   m_valid    result valid
//   m_ready    downstream accepts result
//   m_data     captured result
//   m_err      upper-half check flag (see HD_STAGER_UPPER_CHECK_EN)
//   busy       high outside LOAD, or in LOAD with a partial operand
//   dbg_state  current FSM state (0 LOAD, 1 SETTLE, 2 OUT)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its data stable until that transfer;
// ready may be asserted or withdrawn freely. s_ready and busy are decoded only
// from registered state, so no combinational path exists from s_valid or
// m_ready to any output.
//
// Configuration macro: HD_STAGER_UPPER_CHECK_EN
//   defined   : m_err captures |core_y[31:16] alongside m_data
//   undefined : m_err is tied to 0 and no check logic exists
// ---------------------------------------------------------------------------
module hd_operand_stager #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic [31:0] core_x,
    input  logic [31:0] core_y,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    // Count value on the edge that captures the core result.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [31:0] core_x_q, core_x_d;
    logic [31:0] m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;

    logic        byte_fire;
    logic        last_byte;
    logic        capture;
    logic        out_fire;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    assign byte_fire = s_valid && s_ready;
    assign last_byte = byte_fire && (byte_cnt_q == 2'd3);
    assign capture   = (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);
    assign out_fire  = m_valid_q && m_ready;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_LOAD;
        end else begin
            unique case (state_q)
                ST_LOAD:   if (last_byte) state_d = ST_SETTLE;
                ST_SETTLE: if (capture)   state_d = ST_OUT;
                ST_OUT:    if (out_fire)  state_d = ST_LOAD;
                default:                  state_d = ST_LOAD;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from registered state
    // -----------------------------------------------------------------------
    always_comb begin
        s_ready   = 1'b0;
        busy      = 1'b1;
        dbg_state = state_q;
        unique case (state_q)
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = (byte_cnt_q != 2'd0);
            end
            ST_SETTLE: begin
                s_ready = 1'b0;
                busy    = 1'b1;
            end
            ST_OUT: begin
                s_ready = 1'b0;
                busy    = 1'b1;
            end
            default: begin
                s_ready = 1'b0;
                busy    = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        settle_cnt_d = settle_cnt_q;
        core_x_d     = core_x_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;

        if (clr) begin
            // Abort drops progress only; core_x and the last result are kept.
            byte_cnt_d   = 2'd0;
            settle_cnt_d = 4'd0;
            m_valid_d    = 1'b0;
        end else begin
            if (byte_fire) begin
                core_x_d[{byte_cnt_q, 3'b000} +: 8] = s_data;
                // 2-bit counter wraps 3 -> 0 on the fourth byte.
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (last_byte) begin
                    settle_cnt_d = 4'd0;
                end
            end

            if (state_q == ST_SETTLE) begin
                settle_cnt_d = settle_cnt_q + 4'd1;
            end

            if (capture) begin
                m_data_d  = core_y;
                m_valid_d = 1'b1;
            end

            if (out_fire) begin
                m_valid_d = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q   <= 2'd0;
            settle_cnt_q <= 4'd0;
            core_x_q     <= 32'h0000_0000;
            m_data_q     <= 32'h0000_0000;
            m_valid_q    <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            core_x_q     <= core_x_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign core_x  = core_x_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;

    // -----------------------------------------------------------------------
    // Upper-half check: the present core drives y16..y31 to zero, so any set
    // bit there at capture points at a core or netlist-mapping fault.
    // -----------------------------------------------------------------------
`ifdef HD_STAGER_UPPER_CHECK_EN
    logic m_err_q, m_err_d;

    always_comb begin
        m_err_d = m_err_q;
        if (!clr && capture) begin
            m_err_d = |core_y[31:16];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_err_q <= 1'b0;
        end else begin
            m_err_q <= m_err_d;
        end
    end

    assign m_err = m_err_q;
`else
    assign m_err = 1'b0;
`endif

endmodule

// File: tb/tb_hd_operand_stager.sv
module tb_hd_operand_stager;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        m_ready = 1'b0;
    logic        s_ready;
    logic [31:0] core_x;
    logic [31:0] core_y;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_err;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    // ---------------------------------------------------------------------
    // Clock
    // ---------------------------------------------------------------------
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Core stand-in: a simple function of x, or a forced value
    // ---------------------------------------------------------------------
    logic        ovr_en  = 1'b0;
    logic [31:0] ovr_val = 32'h0;

    function automatic logic [31:0] core_fn(input logic [31:0] x);
        logic [15:0] hi;
        hi = (x[31:28] == 4'hF) ? 16'h0001 : 16'h0000;
        return {hi, x[15:0] ^ x[31:16]};
    endfunction

    assign core_y = ovr_en ? ovr_val : core_fn(core_x);

    function automatic logic exp_err_of(input logic [31:0] y);
`ifdef HD_STAGER_UPPER_CHECK_EN
        return |y[31:16];
`else
        return 1'b0;
`endif
    endfunction

    // ---------------------------------------------------------------------
    // DUT
    // ---------------------------------------------------------------------
    hd_operand_stager #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .core_x    (core_x),
        .core_y    (core_y),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_err     (m_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: no DUT response within cycle budget", name);
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: bytes gathered into a word, a timestamp for the
    // completing byte, and a single result slot.
    // ---------------------------------------------------------------------
    logic [31:0] mdl_x    = 32'h0;
    logic [31:0] mdl_data = 32'h0;
    logic        mdl_err  = 1'b0;
    int          mdl_n    = 0;
    bit          mdl_pend = 1'b0;
    bit          mdl_val  = 1'b0;
    longint      cyc      = 0;
    longint      mdl_done = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_x    = 32'h0;
            mdl_data = 32'h0;
            mdl_err  = 1'b0;
            mdl_n    = 0;
            mdl_pend = 1'b0;
            mdl_val  = 1'b0;
        end else begin
            cyc++;
            if (clr) begin
                mdl_n    = 0;
                mdl_pend = 1'b0;
                mdl_val  = 1'b0;
            end else if (!mdl_pend && !mdl_val) begin
                if (s_valid) begin
                    mdl_x[8*mdl_n +: 8] = s_data;
                    mdl_n++;
                    if (mdl_n == 4) begin
                        mdl_n    = 0;
                        mdl_pend = 1'b1;
                        mdl_done = cyc;
                    end
                end
            end else if (mdl_pend) begin
                if (cyc == mdl_done + SETTLE) begin
                    mdl_val  = 1'b1;
                    mdl_data = core_y;
                    mdl_err  = exp_err_of(core_y);
                    mdl_pend = 1'b0;
                end
            end else if (mdl_val && m_ready) begin
                mdl_val = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Scoreboard compare on every falling edge
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        logic [1:0] exp_state;
        exp_state = mdl_val ? 2'd2 : (mdl_pend ? 2'd1 : 2'd0);
        chk("sb_s_ready", {31'b0, s_ready}, {31'b0, !mdl_pend && !mdl_val});
        chk("sb_busy", {31'b0, busy}, {31'b0, mdl_pend || mdl_val || (mdl_n != 0)});
        chk("sb_m_valid", {31'b0, m_valid}, {31'b0, mdl_val});
        chk("sb_core_x", core_x, mdl_x);
        chk("sb_m_data", m_data, mdl_data);
        chk("sb_m_err", {31'b0, m_err}, {31'b0, mdl_err});
        chk("sb_state", {30'b0, dbg_state}, {30'b0, exp_state});
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  rdy;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        do begin
            rdy = s_ready;
            step();
            n++;
        end while (!rdy && n < 60);
        s_valid = 1'b0;
        if (!rdy) timeout_fail("send_byte");
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_mvalid(output int lat);
        lat = 0;
        while (!m_valid && lat < 60) begin
            step();
            lat++;
        end
        if (!m_valid) timeout_fail("wait_mvalid");
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int          lat;
        logic [31:0] w;
        logic [7:0]  basic_bytes [4];
        int          pat [7];
        int          k;

        basic_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
        pat         = '{1, 0, 0, 1, 1, 0, 1};

        // Reset
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_core_x", core_x, 32'h0000_0000);

        // Basic operand, consecutive bytes, m_ready held high
        m_ready = 1'b1;
        ovr_en  = 1'b1;
        ovr_val = 32'h0000_ABCD;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = basic_bytes[i];
            step();
        end
        s_valid = 1'b0;
        chk("basic_core_x", core_x, 32'h1234_5678);
        wait_mvalid(lat);
        chk("basic_latency", lat, 32'd2);
        chk("basic_m_data", m_data, 32'h0000_ABCD);
        step();
        chk("basic_drain", {31'b0, m_valid}, 32'd0);
        ovr_en = 1'b0;

        // Back-pressure
        m_ready = 1'b0;
        w = $urandom;
        send_word(w);
        wait_mvalid(lat);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_m_data", m_data, core_fn(w));
            chk("bp_s_ready", {31'b0, s_ready}, 32'd0);
        end
        s_valid = 1'b0;
        chk("bp_core_x", core_x, w);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("bp_m_valid_low", {31'b0, m_valid}, 32'd0);
        chk("bp_s_ready_high", {31'b0, s_ready}, 32'd1);

        // Gapped input
        m_ready = 1'b1;
        w = $urandom;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            s_valid = (pat[i] != 0);
            s_data  = (pat[i] != 0) ? w[8*k +: 8] : 8'($urandom_range(0, 255));
            step();
            if (pat[i] != 0) k++;
            if (i == 0) chk("gap_busy", {31'b0, busy}, 32'd1);
        end
        s_valid = 1'b0;
        chk("gap_core_x", core_x, w);
        wait_mvalid(lat);
        chk("gap_m_data", m_data, core_fn(w));
        step();

        // Abort after two bytes
        send_byte(8'hAA);
        send_byte(8'hBB);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_x_kept", {16'b0, core_x[15:0]}, 32'h0000_BBAA);
        for (int i = 0; i < SETTLE + 3; i++) begin
            step();
            chk("clr_no_result", {31'b0, m_valid}, 32'd0);
        end
        send_word(32'h0403_0201);
        chk("clr_core_x", core_x, 32'h0403_0201);
        wait_mvalid(lat);
        step();

        // Abort coinciding with an output handshake
        m_ready = 1'b0;
        send_word($urandom);
        wait_mvalid(lat);
        m_ready = 1'b1;
        clr     = 1'b1;
        step();
        clr     = 1'b0;
        m_ready = 1'b0;
        chk("clrhs_m_valid", {31'b0, m_valid}, 32'd0);
        chk("clrhs_state", {30'b0, dbg_state}, 32'd0);
        chk("clrhs_s_ready", {31'b0, s_ready}, 32'd1);

        // Upper-half check
        ovr_en  = 1'b1;
        ovr_val = 32'h0001_0000;
        send_word($urandom);
        wait_mvalid(lat);
        chk("err_m_data", m_data, 32'h0001_0000);
`ifdef HD_STAGER_UPPER_CHECK_EN
        chk("err_flag", {31'b0, m_err}, 32'd1);
`else
        chk("err_flag", {31'b0, m_err}, 32'd0);
`endif
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        ovr_en  = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom_range(0, 255));
            m_ready = ($urandom_range(0, 3) != 0);
            clr     = ($urandom_range(0, 39) == 0);
            step();
        end
        clr     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (SETTLE + 3) step();

        // Asynchronous reset in the middle of an operand
        m_ready = 1'b0;
        send_byte(8'h3C);
        send_byte(8'hC3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_core_x", core_x, 32'h0000_0000);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_s_ready", {31'b0, s_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
